sixty_ctrl: RTL and testbench
=============================

Name: sixty_ctrl

Overview:
Run controller for the mod-60 seconds counter, built as a units digit (mod 10) cascaded with a tens digit (mod 6).
- Divides clk into a count tick.
- Sequences run, pause and clear.
- Provides a manual digit-set mode.
- Emits a wrap carry and an alarm-match pulse.
It sits between the debounced panel buttons and the display or minute stage. The counter digits are held inside this block as registered BCD.

Parameters:
TICK_DIV, 100_000_000, clk cycles per count tick (>=2); prescaler width = $clog2(TICK_DIV)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
start  input  1  single-cycle pulse: begin or resume counting
stop  input  1  single-cycle pulse: pause counting
clear  input  1  single-cycle pulse: zero digits, go idle
btn_mode  input  1  single-cycle pulse: step through set states
btn_inc  input  1  single-cycle pulse: increment the selected digit
alarm_en  input  1  level: alarm compare enable
alarm_tens  input  3  alarm tens digit, BCD 0-5
alarm_units  input  4  alarm units digit, BCD 0-9
units  output  4  registered units digit, 0-9
tens  output  3  registered tens digit, 0-5
carry  output  1  one-cycle pulse on the 59->00 wrap
alarm  output  1  one-cycle pulse on a counted alarm match
running  output  1  high in RUN state
state  output  3  IDLE=0, RUN=1, PAUSE=2, SET_U=3, SET_T=4

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, units=0, tens=0, prescaler=0, carry=0, alarm=0, running=0.
- Input priority per cycle: clear > stop > start > btn_mode > btn_inc.
- clear, in any state: digits=0, prescaler=0, state=IDLE next cycle. carry and alarm stay 0 that cycle, even if a tick coincides.
- IDLE or PAUSE:
  - start -> RUN.
  - btn_mode -> SET_U, and prescaler is cleared.
- RUN:
  - stop -> PAUSE. The prescaler value is held.
  - btn_mode and btn_inc are ignored.
  - start and stop in the same cycle: stop wins.
- SET_U:
  - btn_inc: units+1, wrapping 9->0 with no effect on tens.
  - btn_mode -> SET_T.
  - start and stop are ignored.
- SET_T:
  - btn_inc: tens+1, wrapping 5->0.
  - btn_mode -> PAUSE.
- Prescaler:
  - Counts only in RUN, 0..TICK_DIV-1.
  - tick is asserted internally when the prescaler equals TICK_DIV-1 in RUN; the prescaler returns to 0 at that point.
  - First tick after start from a cleared prescaler falls TICK_DIV cycles after the start cycle.
- On tick, digits update on the same clock edge (visible the cycle after tick):
  - units<9: units+1.
  - units==9, tens<5: units=0, tens+1.
  - units==9, tens==5: units=0, tens=0, carry=1 for exactly one cycle.
- A stop in the same cycle as a tick suppresses that tick: no digit change, no carry.
- Alarm:
  - Fires when alarm_en=1 and a tick produces a new value equal to {alarm_tens, alarm_units}.
  - alarm=1 for one cycle, aligned with the digit update.
  - Values reached via set mode or clear never fire it.
  - Out-of-range alarm inputs (units>9 or tens>5) never match.
- Outputs:
  - carry, alarm and running are registered.
  - running = (state==RUN).
  - state is a direct register.
- Reset asserted mid-count aborts immediately to the reset values. Counting resumes only after a fresh start.

Test Plan (TICK_DIV=4):
- Reset, then start; hold 12 cycles -> digits 00 -> 01 -> 02 -> 03, one step every 4 cycles, first step 4 cycles after start; running=1.
- Preset 5,8 via set mode (mode, inc x8, mode, inc x5, mode) -> state PAUSE, tens=5, units=8. Then start -> 59, then 00 with carry=1 for exactly one cycle, then 01.
- Count to 03, stop, wait 10 cycles -> holds 03. Then start -> 04 after the remaining prescaler cycles; pause must not lose or double a tick.
- alarm_en=1, alarm=0,5, count from 00 -> alarm pulses once when 05 appears. Then set units to 5 manually -> no alarm.
- clear asserted on the same cycle as a 59->00 tick -> digits 00, state IDLE, carry=0. Also: start+stop in the same cycle from RUN -> PAUSE.
- Assert rst=0 mid-count at 37 -> outputs zero asynchronously, state IDLE. After release, digits do not move until start.

Source files
------------

// File: rtl/sixty_ctrl.sv
// Run controller for a mod-60 BCD seconds counter: tick prescaler, run/pause/clear
// sequencing, manual digit set, wrap carry and alarm-match pulse.
module sixty_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_en,
  input  logic [2:0] alarm_tens,
  input  logic [3:0] alarm_units,
  output logic [3:0] units,
  output logic [2:0] tens,
  output logic       carry,
  output logic       alarm,
  output logic       running,
  output logic [2:0] state
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    SET_U = 3'd3,
    SET_T = 3'd4
  } state_e;

  state_e        r_state;
  logic [3:0]    r_units;
  logic [2:0]    r_tens;
  logic [PW-1:0] r_presc;
  logic          r_carry;
  logic          r_alarm;
  logic          r_running;

  state_e        w_state_nxt;
  logic [3:0]    w_units_nxt;
  logic [2:0]    w_tens_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_carry_nxt;
  logic          w_alarm_nxt;
  logic          w_alarm_valid;

  // Out-of-range alarm settings are never allowed to match.
  assign w_alarm_valid = alarm_en && (alarm_units <= 4'd9) && (alarm_tens <= 3'd5);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_units   <= 4'd0;
      r_tens    <= 3'd0;
      r_presc   <= '0;
      r_carry   <= 1'b0;
      r_alarm   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_units   <= w_units_nxt;
      r_tens    <= w_tens_nxt;
      r_presc   <= w_presc_nxt;
      r_carry   <= w_carry_nxt;
      r_alarm   <= w_alarm_nxt;
      r_running <= (w_state_nxt == RUN);
    end
  end

  // Next state, digits and pulses; priority clear > stop > start > mode > inc.
  always_comb begin
    w_state_nxt = r_state;
    w_units_nxt = r_units;
    w_tens_nxt  = r_tens;
    w_presc_nxt = r_presc;
    w_carry_nxt = 1'b0;
    w_alarm_nxt = 1'b0;

    if (clear) begin
      w_state_nxt = IDLE;
      w_units_nxt = 4'd0;
      w_tens_nxt  = 3'd0;
      w_presc_nxt = '0;
    end else begin
      case (r_state)
        IDLE, PAUSE: begin
          if (!stop) begin
            if (start) begin
              w_state_nxt = RUN;
            end else if (btn_mode) begin
              w_state_nxt = SET_U;
              w_presc_nxt = '0;
            end
          end
        end
        RUN: begin
          // A stop landing on a tick suppresses it; the prescaler keeps its value.
          if (stop) begin
            w_state_nxt = PAUSE;
          end else if (r_presc == PRESC_TOP) begin
            w_presc_nxt = '0;
            if (r_units != 4'd9) begin
              w_units_nxt = r_units + 4'd1;
            end else begin
              w_units_nxt = 4'd0;
              if (r_tens != 3'd5) begin
                w_tens_nxt = r_tens + 3'd1;
              end else begin
                w_tens_nxt  = 3'd0;
                w_carry_nxt = 1'b1;
              end
            end
            w_alarm_nxt = w_alarm_valid && (w_units_nxt == alarm_units) &&
                          (w_tens_nxt == alarm_tens);
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
        SET_U: begin
          if (btn_mode) begin
            w_state_nxt = SET_T;
          end else if (btn_inc) begin
            w_units_nxt = (r_units == 4'd9) ? 4'd0 : r_units + 4'd1;
          end
        end
        SET_T: begin
          if (btn_mode) begin
            w_state_nxt = PAUSE;
          end else if (btn_inc) begin
            w_tens_nxt = (r_tens == 3'd5) ? 3'd0 : r_tens + 3'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign units   = r_units;
  assign tens    = r_tens;
  assign carry   = r_carry;
  assign alarm   = r_alarm;
  assign running = r_running;
  assign state   = r_state;

endmodule

// File: tb/tb_sixty_ctrl.sv
// Scoreboard bench for sixty_ctrl: every digit change or pulse is an event that must
// match the next expected entry (cycle, digits, carry, alarm) pushed when stimulus was driven.
module tb_sixty_ctrl;

  localparam int unsigned TD = 4;
  localparam int P_START = 0, P_STOP = 1, P_CLEAR = 2, P_MODE = 3, P_INC = 4, P_BOTH = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic       alarm_en = 1'b0;
  logic [2:0] alarm_tens = 3'd0;
  logic [3:0] alarm_units = 4'd0;
  logic [3:0] units;
  logic [2:0] tens;
  logic       carry, alarm, running;
  logic [2:0] state;

  sixty_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .alarm_en(alarm_en),
    .alarm_tens(alarm_tens), .alarm_units(alarm_units),
    .units(units), .tens(tens), .carry(carry), .alarm(alarm),
    .running(running), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int cy; int t; int u; int c; int a; } evt_t;
  evt_t exp_q[$];
  evt_t mon_ev;

  int n_chk = 0, n_pass = 0;
  int e_t = 0, e_u = 0;
  bit al_on = 1'b0;
  int al_t = 0, al_u = 0;
  bit mon_en = 1'b0;
  int prev_t = 0, prev_u = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic void push_evt(input int cy, input int c, input int a);
    evt_t e;
    e.cy = cy; e.t = e_t; e.u = e_u; e.c = c; e.a = a;
    exp_q.push_back(e);
  endfunction

  function automatic void model_tick(input int cy);
    int c = 0;
    int a;
    if (e_u < 9) e_u++;
    else begin
      e_u = 0;
      if (e_t < 5) e_t++;
      else begin e_t = 0; c = 1; end
    end
    a = (al_on && al_u <= 9 && al_t <= 5 && e_u == al_u && e_t == al_t) ? 1 : 0;
    push_evt(cy, c, a);
  endfunction

  // Event monitor: any visible change must be the next scoreboard entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(tens) != prev_t || int'(units) != prev_u || carry || alarm) begin
        check("evt_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_ev = exp_q.pop_front();
          check("evt_cycle", cyc, mon_ev.cy);
          check("evt_tens", int'(tens), mon_ev.t);
          check("evt_units", int'(units), mon_ev.u);
          check("evt_carry", int'(carry), mon_ev.c);
          check("evt_alarm", int'(alarm), mon_ev.a);
        end
      end
      prev_t = int'(tens);
      prev_u = int'(units);
    end
  end

  task automatic drive(input int which);
    case (which)
      P_START: start = 1'b1;
      P_STOP:  stop = 1'b1;
      P_CLEAR: clear = 1'b1;
      P_MODE:  btn_mode = 1'b1;
      P_INC:   btn_inc = 1'b1;
      default: begin start = 1'b1; stop = 1'b1; end
    endcase
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_start(output int ed);
    ed = cyc + 1;
    drive(P_START);
    check("start_state", int'(state), 1);
    check("start_running", int'(running), 1);
  endtask

  task automatic do_stop();
    drive(P_STOP);
    check("stop_state", int'(state), 2);
    check("stop_running", int'(running), 0);
  endtask

  task automatic do_clear();
    int ed;
    ed = cyc + 1;
    if (e_t != 0 || e_u != 0) begin
      e_t = 0; e_u = 0;
      push_evt(ed, 0, 0);
    end
    drive(P_CLEAR);
    check("clear_state", int'(state), 0);
    check("clear_carry", int'(carry), 0);
  endtask

  task automatic do_inc_u();
    e_u = (e_u == 9) ? 0 : e_u + 1;
    push_evt(cyc + 1, 0, 0);
    drive(P_INC);
  endtask

  task automatic do_inc_t();
    e_t = (e_t == 5) ? 0 : e_t + 1;
    push_evt(cyc + 1, 0, 0);
    drive(P_INC);
  endtask

  task automatic preset(input int t, input int u);
    drive(P_MODE);
    check("set_u_state", int'(state), 3);
    drive(P_START);
    check("setu_ignore_start", int'(state), 3);
    drive(P_STOP);
    check("setu_ignore_stop", int'(state), 3);
    while (e_u != u) do_inc_u();
    drive(P_MODE);
    check("set_t_state", int'(state), 4);
    while (e_t != t) do_inc_t();
    drive(P_MODE);
    check("set_done_state", int'(state), 2);
    check("preset_tens", int'(tens), t);
    check("preset_units", int'(units), u);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 40) begin @(negedge clk); n++; end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0, r1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_units", int'(units), 0);
    check("rst_tens", int'(tens), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_alarm", int'(alarm), 0);
    check("rst_running", int'(running), 0);
    check("rst_state", int'(state), 0);
    rst = 1'b1;
    prev_t = 0; prev_u = 0; mon_en = 1'b1;
    @(negedge clk);

    // Basic count, pause/resume, and a stop that lands on a tick.
    do_start(e0);
    for (int k = 1; k <= 3; k++) model_tick(e0 + 4 * k);
    wait_to(e0 + 12);
    check("t1_units_03", int'(units), 3);
    wait_to(e0 + 13);
    do_stop();
    repeat (10) @(negedge clk);
    check("t1_hold_03", int'(units), 3);
    do_start(r0);
    model_tick(r0 + 3);
    wait_to(r0 + 3);
    check("t1_resume_04", int'(units), 4);
    wait_to(r0 + 6);
    do_stop();
    repeat (5) @(negedge clk);
    check("t1_suppressed_04", int'(units), 4);
    do_start(r1);
    model_tick(r1 + 1);
    wait_to(r1 + 1);
    check("t1_tick_kept_05", int'(units), 5);
    do_stop();
    do_clear();
    drain();

    // Preset 58 and count through the 59->00 wrap.
    preset(5, 8);
    do_start(e0);
    for (int k = 1; k <= 3; k++) model_tick(e0 + 4 * k);
    wait_to(e0 + 12);
    check("t2_tens_01", int'(tens), 0);
    check("t2_units_01", int'(units), 1);
    do_clear();
    drain();

    // Alarm on counted 05, ignored buttons in RUN, set-mode values never alarm.
    al_on = 1'b1; al_t = 0; al_u = 5;
    alarm_en = 1'b1; alarm_tens = 3'd0; alarm_units = 4'd5;
    do_start(e0);
    drive(P_MODE);
    drive(P_INC);
    check("run_ignore_mode", int'(state), 1);
    for (int k = 1; k <= 6; k++) model_tick(e0 + 4 * k);
    wait_to(e0 + 24);
    do_stop();
    do_clear();
    preset(0, 5);
    preset(2, 4);
    preset(4, 1);
    preset(1, 1);
    al_on = 1'b0; alarm_en = 1'b0;
    do_clear();
    drain();

    // Clear colliding with the 59->00 tick, then start+stop together.
    preset(5, 9);
    do_start(e0);
    wait_to(e0 + 3);
    do_clear();
    check("t5_state_idle", int'(state), 0);
    do_start(e0);
    wait_to(e0 + 1);
    drive(P_BOTH);
    check("both_state", int'(state), 2);
    check("both_running", int'(running), 0);
    do_clear();
    drain();

    // Asynchronous reset at 37; nothing moves afterwards without a start.
    preset(3, 6);
    do_start(e0);
    model_tick(e0 + 4);
    wait_to(e0 + 5);
    @(posedge clk);
    #1;
    e_t = 0; e_u = 0;
    push_evt(e0 + 6, 0, 0);
    rst = 1'b0;
    #1;
    check("arst_units", int'(units), 0);
    check("arst_tens", int'(tens), 0);
    check("arst_state", int'(state), 0);
    check("arst_running", int'(running), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_units", int'(units), 0);
    check("post_rst_state", int'(state), 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
